// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID/EX/issue/writeback stages and the hazard scoreboard.
// master drives the pipeline view; slave is the scoreboard side.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int CW = 3
) ();
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic [AW-1:0] id_rd;
  logic [4:0]    id_opcode;
  logic          id_funct3;
  logic          id_long;
  logic          ex_valid;
  logic          ex_load;
  logic [AW-1:0] ex_rd;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          hazard_stall;
  logic          busy;
  logic [CW-1:0] outstanding;
  logic          err;

  modport master (
    output id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_long,
           ex_valid, ex_load, ex_rd, issue_valid, issue_rd, wb_valid, wb_rd,
    input  issue_ready, hazard_stall, busy, outstanding, err
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_long,
           ex_valid, ex_load, ex_rd, issue_valid, issue_rd, wb_valid, wb_rd,
    output issue_ready, hazard_stall, busy, outstanding, err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector with per-register pending counters for long-latency writers.
// Optional HAZARD_WB_BYPASS_EN: a register whose last pending write is being written back does not stall ID.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_scoreboard_if.slave   bus
);

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_nxt;
  logic          err_q;
  logic          err_nxt;

  logic uses_rs1, uses_rs2;
  logic pend_rs1, pend_rs2, pend_rd;
  logic loaduse, raw, waw, full;
  logic issue_ready;
  logic issue_err, wb_err, sat_err;
  logic issue_do, wb_do;

  function automatic logic uses_rs1_f(input logic [4:0] op, input logic f3);
    return (op[4:1] == 4'b1100) || (op == 5'b00000) || (op == 5'b01000) ||
           (op == 5'b00100) || (op == 5'b01100) || ((op == 5'b11100) && !f3);
  endfunction

  function automatic logic uses_rs2_f(input logic [4:0] op);
    return (op == 5'b11000) || (op == 5'b01000) || (op == 5'b01100);
  endfunction

  // x0 never pends; with the bypass, the retiring last write is already visible through the regfile.
  function automatic logic pend_f(input logic [AW-1:0] r, input logic [CW-1:0] c,
                                  input logic wbv, input logic [AW-1:0] wbr);
    logic p;
    p = (r != '0) && (c != '0);
`ifdef HAZARD_WB_BYPASS_EN
    if (wbv && (wbr == r) && (c == CW'(1))) p = 1'b0;
`else
    if (wbv && (wbr == r) && 1'b0) p = 1'b0;
`endif
    return p;
  endfunction

  assign uses_rs1    = uses_rs1_f(bus.id_opcode, bus.id_funct3);
  assign uses_rs2    = uses_rs2_f(bus.id_opcode);
  assign issue_ready = (outstanding_q < CW'(MAX_OUT));

  assign pend_rs1 = pend_f(bus.id_rs1, cnt[bus.id_rs1], bus.wb_valid, bus.wb_rd);
  assign pend_rs2 = pend_f(bus.id_rs2, cnt[bus.id_rs2], bus.wb_valid, bus.wb_rd);
  assign pend_rd  = pend_f(bus.id_rd,  cnt[bus.id_rd],  bus.wb_valid, bus.wb_rd);

  assign loaduse = bus.ex_valid && bus.ex_load && (bus.ex_rd != '0) &&
                   ((uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  assign raw  = (uses_rs1 && pend_rs1) || (uses_rs2 && pend_rs2);
  assign waw  = pend_rd;
  assign full = bus.id_long && !issue_ready;

  assign bus.hazard_stall = loaduse || raw || waw || full;
  assign bus.issue_ready  = issue_ready;
  assign bus.busy         = (outstanding_q != '0);
  assign bus.outstanding  = outstanding_q;
  assign bus.err          = err_q;

  // Protocol checks: an offending issue or writeback is dropped rather than corrupting counts.
  assign issue_err = bus.issue_valid && !issue_ready;
  assign sat_err   = bus.issue_valid && issue_ready && (bus.issue_rd != '0) &&
                     (cnt[bus.issue_rd] == CW'(MAX_OUT));
  assign wb_err    = bus.wb_valid &&
                     (((bus.wb_rd != '0) && (cnt[bus.wb_rd] == '0)) || (outstanding_q == '0));
  assign issue_do  = bus.issue_valid && issue_ready && !sat_err;
  assign wb_do     = bus.wb_valid && !wb_err;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r != 0) begin
        if (issue_do && (bus.issue_rd == AW'(r))) cnt_nxt[r] = cnt_nxt[r] + CW'(1);
        if (wb_do && (bus.wb_rd == AW'(r)))       cnt_nxt[r] = cnt_nxt[r] - CW'(1);
      end else begin
        cnt_nxt[r] = '0;
      end
    end
    outstanding_nxt = outstanding_q + CW'(issue_do) - CW'(wb_do);
    err_nxt         = err_q || issue_err || wb_err || sat_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      outstanding_q <= outstanding_nxt;
      err_q         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected output snapshots are queued and popped at each sample point.
module tb_hazard_scoreboard;
  localparam logic [4:0] OP    = 5'b01100;
  localparam logic [4:0] OPIMM = 5'b00100;
  localparam logic [4:0] LUI   = 5'b01101;
  localparam logic [4:0] STORE = 5'b01000;
  localparam logic [4:0] SYS   = 5'b11100;
`ifdef HAZARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus ();
  hazard_scoreboard dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    string      tag;
    logic       stall;
    logic       busy;
    logic       ready;
    logic [2:0] outst;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic cmp(input string tag, input string field, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic st, input logic bs, input logic rdy,
                     input logic [2:0] ot, input logic er);
    exp_t e;
    sb.push_back('{tag: tag, stall: st, busy: bs, ready: rdy, outst: ot, err: er});
    #1;
    e = sb.pop_front();
    cmp(e.tag, "hazard_stall", {2'b0, bus.hazard_stall}, {2'b0, e.stall});
    cmp(e.tag, "busy",         {2'b0, bus.busy},         {2'b0, e.busy});
    cmp(e.tag, "issue_ready",  {2'b0, bus.issue_ready},  {2'b0, e.ready});
    cmp(e.tag, "outstanding",  bus.outstanding,          e.outst);
    cmp(e.tag, "err",          {2'b0, bus.err},          {2'b0, e.err});
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_opcode = LUI; bus.id_funct3 = 1'b0; bus.id_long = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_rd = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0;
  endtask

  task automatic set_id(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic f3);
    bus.id_opcode = op; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd; bus.id_funct3 = f3;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    idle();
    chk("reset", 0, 0, 1, 0, 0);
    tick(); rst_n = 1'b1;

    // Load-use against the EX-stage load
    bus.ex_valid = 1; bus.ex_load = 1; bus.ex_rd = 5;
    set_id(OP, 5, 7, 6, 0);
    chk("loaduse", 1, 0, 1, 0, 0);
    tick(); bus.ex_rd = 0;
    chk("loaduse_x0", 0, 0, 1, 0, 0);
    tick(); bus.ex_rd = 5; set_id(LUI, 5, 5, 6, 0);
    chk("loaduse_lui", 0, 0, 1, 0, 0);
    tick(); idle();

    // AXI load RAW on x10
    bus.issue_valid = 1; bus.issue_rd = 10; set_id(OPIMM, 10, 0, 11, 0);
    chk("raw_issue_cycle", 0, 0, 1, 0, 0);
    tick(); bus.issue_valid = 0;
    chk("raw_pend1", 1, 1, 1, 1, 0);
    tick();
    chk("raw_pend2", 1, 1, 1, 1, 0);
    tick(); set_id(STORE, 0, 10, 0, 0);
    chk("raw_rs2", 1, 1, 1, 1, 0);
    tick(); set_id(SYS, 10, 0, 0, 0);
    chk("raw_csr", 1, 1, 1, 1, 0);
    tick(); set_id(SYS, 10, 0, 0, 1);
    chk("raw_csr_imm", 0, 1, 1, 1, 0);
    tick(); set_id(OPIMM, 10, 0, 11, 0); bus.wb_valid = 1; bus.wb_rd = 10;
    chk("raw_wb_cycle", !BYP, 1, 1, 1, 0);
    tick(); bus.wb_valid = 0;
    chk("raw_released", 0, 0, 1, 0, 0);
    tick(); bus.issue_valid = 1; bus.issue_rd = 10; set_id(LUI, 0, 0, 10, 0);
    chk("waw_issue_cycle", 0, 0, 1, 0, 0);
    tick(); bus.issue_valid = 0;
    chk("waw_lui", 1, 1, 1, 1, 0);
    tick(); bus.wb_valid = 1; bus.wb_rd = 10;
    chk("waw_wb_cycle", !BYP, 1, 1, 1, 0);
    tick(); idle();
    chk("waw_released", 0, 0, 1, 0, 0);

    // Outstanding budget
    for (int i = 1; i <= 4; i++) begin
      tick(); bus.issue_valid = 1; bus.issue_rd = 5'(i);
    end
    tick(); bus.issue_valid = 0;
    chk("budget_full", 0, 1, 0, 4, 0);
    bus.id_long = 1;
    chk("budget_long_stall", 1, 1, 0, 4, 0);
    tick(); bus.id_long = 0; bus.issue_valid = 1; bus.issue_rd = 5;
    chk("budget_over_issue", 0, 1, 0, 4, 0);
    tick(); bus.issue_valid = 0; set_id(OPIMM, 5, 0, 0, 0);
    chk("budget_err", 0, 1, 0, 4, 1);
    tick(); idle(); bus.wb_valid = 1; bus.wb_rd = 2;
    tick(); bus.wb_valid = 0; set_id(OP, 2, 0, 0, 0);
    chk("budget_release", 0, 1, 1, 3, 1);
    tick(); set_id(OP, 2, 3, 0, 0);
    chk("budget_x3_pend", 1, 1, 1, 3, 1);

    // Asynchronous reset with writes in flight
    tick(); rst_n = 1'b0;
    chk("reset_midflight", 0, 0, 1, 0, 0);
    tick(); rst_n = 1'b1; idle();

    // Simultaneous issue and writeback
    bus.issue_valid = 1; bus.issue_rd = 7;
    tick(); bus.issue_valid = 0; set_id(OPIMM, 7, 0, 0, 0);
    chk("sim_pend7", 1, 1, 1, 1, 0);
    tick(); idle(); bus.issue_valid = 1; bus.issue_rd = 7; bus.wb_valid = 1; bus.wb_rd = 7;
    chk("sim_same_cycle", 0, 1, 1, 1, 0);
    tick(); idle(); set_id(OPIMM, 7, 0, 0, 0);
    chk("sim_same_after", 1, 1, 1, 1, 0);
    tick(); idle(); bus.issue_valid = 1; bus.issue_rd = 8; bus.wb_valid = 1; bus.wb_rd = 7;
    tick(); idle(); set_id(OPIMM, 7, 0, 0, 0);
    chk("sim_diff_x7", 0, 1, 1, 1, 0);
    tick(); set_id(OPIMM, 8, 0, 0, 0);
    chk("sim_diff_x8", 1, 1, 1, 1, 0);

    // Underflow and x0 budget accounting
    tick(); idle(); bus.wb_valid = 1; bus.wb_rd = 9;
    tick(); bus.wb_valid = 0;
    chk("underflow", 0, 1, 1, 1, 1);
    bus.wb_valid = 1; bus.wb_rd = 8;
    tick(); bus.wb_valid = 0;
    chk("drain", 0, 0, 1, 0, 1);
    bus.issue_valid = 1; bus.issue_rd = 0;
    tick(); bus.issue_valid = 0; set_id(OP, 0, 0, 0, 0);
    chk("x0_budget", 0, 1, 1, 1, 1);
    tick(); idle(); bus.wb_valid = 1; bus.wb_rd = 0;
    tick(); bus.wb_valid = 0;
    chk("x0_release", 0, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
